// File: rtl/writeback_pkg.sv
// Shared constants and dump FSM encoding for the writeback stage.
package writeback_pkg;
  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;
  localparam int REG_COUNT   = 32;
  localparam int REG_AW      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } dump_state_t;
endpackage

// File: rtl/writeback_regfile.sv
// 32x32 register file: one write port and three read ports that see a same-cycle write.
module regfile
  import writeback_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [31:0]       rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [31:0]       rdata_b,
  input  logic [REG_AW-1:0] raddr_c,
  output logic [31:0]       rdata_c
);
  logic [31:0] mem [REG_COUNT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  // Entry 0 is never written, but the read mux forces it to zero regardless.
  assign rdata_a = (raddr_a == '0) ? '0 : (we && raddr_a == waddr) ? wdata : mem[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : (we && raddr_b == waddr) ? wdata : mem[raddr_b];
  assign rdata_c = (raddr_c == '0) ? '0 : (we && raddr_c == waddr) ? wdata : mem[raddr_c];
endmodule

// File: rtl/writeback.sv
// Writeback stage: result mux, forwarding outputs and a handshaked register-file dump.
// state | meaning
// IDLE  | waiting for dump_start
// SEND  | presenting dump_index/dump_data until accepted
// DONE  | one-cycle dump_done pulse, then back to IDLE
module writeback
  import writeback_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        wbi,
  input  logic [REG_AW-1:0] regaddr,
  input  logic [31:0]       datafrommem,
  input  logic [31:0]       datafromimm,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic [31:0]       rs_data,
  output logic [31:0]       rt_data,
  output logic              fwd_we,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [31:0]       fwd_data,
  input  logic              dump_start,
  output logic              dump_valid,
  output logic [REG_AW-1:0] dump_index,
  output logic [31:0]       dump_data,
  input  logic              dump_ready,
  output logic              dump_busy,
  output logic              dump_done
);
  dump_state_t       state;
  logic [31:0]       wbdata;
  logic [REG_AW-1:0] dump_raddr;
  logic [31:0]       dump_rdata;

  assign wbdata   = wbi[WB_MEMTOREG] ? datafrommem : datafromimm;
  assign fwd_we   = wbi[WB_REGWRITE] && (regaddr != '0);
  assign fwd_addr = regaddr;
  assign fwd_data = wbdata;

  // The third port looks one entry ahead so the next snapshot is ready on acceptance.
  assign dump_raddr = (state == SEND) ? dump_index + 5'd1 : '0;

  regfile u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (fwd_we),
    .waddr   (regaddr),
    .wdata   (wbdata),
    .raddr_a (rs_addr),
    .rdata_a (rs_data),
    .raddr_b (rt_addr),
    .rdata_b (rt_data),
    .raddr_c (dump_raddr),
    .rdata_c (dump_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
      dump_busy  <= 1'b0;
      dump_index <= '0;
      dump_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          dump_done <= 1'b0;
          if (dump_start) begin
            state      <= SEND;
            dump_valid <= 1'b1;
            dump_busy  <= 1'b1;
            dump_index <= '0;
            dump_data  <= dump_rdata;
          end
        end
        SEND: begin
          if (dump_ready) begin
            if (dump_index == 5'd31) begin
              state      <= DONE;
              dump_valid <= 1'b0;
              dump_done  <= 1'b1;
            end else begin
              dump_index <= dump_index + 5'd1;
              dump_data  <= dump_rdata;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          dump_done <= 1'b0;
          dump_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          dump_valid <= 1'b0;
          dump_done  <= 1'b0;
          dump_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
